// File: rtl/mlp_ctrl_pkg.sv
// Shared constants for the MLP inference sequencer: FSM state encoding,
// default geometry of the bespoke classifier and the feature-index width helper.
package mlp_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Default classifier geometry
  localparam int unsigned NUM_A_DEF    = 21;
  localparam int unsigned WIDTH_A_DEF  = 4;
  localparam int unsigned OUTWIDTH_DEF = 2;

  // Width of the feature index counter; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_feat_assembler.sv
// Feature assembler: counts accepted features and writes each one into its
// slice of the registered MLP input bus. On the last feature of a sample the
// whole bus is XORed with inj_mask_i (all-zero unless fault injection is used).
module mlp_feat_assembler
  import mlp_ctrl_pkg::*;
#(
  parameter int unsigned NUM_A   = NUM_A_DEF,
  parameter int unsigned WIDTH_A = WIDTH_A_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       load_en_i,
  input  logic                       s_valid_i,
  input  logic [WIDTH_A-1:0]         s_data_i,
  input  logic [NUM_A*WIDTH_A-1:0]   inj_mask_i,
  output logic                       wr_en_o,
  output logic                       last_o,
  output logic [NUM_A*WIDTH_A-1:0]   bus_o
);

  localparam int unsigned IDX_W = idx_width(NUM_A);
  localparam int unsigned BUS_W = NUM_A * WIDTH_A;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);

  logic [IDX_W-1:0] feat_idx_q, feat_idx_d;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic             wr_en_s;
  logic             at_last_s;

  // A clear in the same cycle discards the handshake entirely
  assign wr_en_s   = load_en_i & s_valid_i & ~clear_i;
  assign at_last_s = (feat_idx_q == LAST_IDX);
  assign wr_en_o   = wr_en_s;
  assign last_o    = at_last_s;
  assign bus_o     = bus_q;

  // Next-state: slice write, index advance/wrap, mask applied on the final feature
  always_comb begin
    feat_idx_d = feat_idx_q;
    bus_d      = bus_q;
    if (clear_i) begin
      feat_idx_d = '0;
    end else if (wr_en_s) begin
      bus_d[feat_idx_q*WIDTH_A +: WIDTH_A] = s_data_i;
      if (at_last_s) begin
        feat_idx_d = '0;
        bus_d      = bus_d ^ inj_mask_i;
      end else begin
        feat_idx_d = feat_idx_q + 1'b1;
      end
    end else begin
      feat_idx_d = feat_idx_q;
    end
  end

  // Index and bus registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      feat_idx_q <= '0;
      bus_q      <= '0;
    end else begin
      feat_idx_q <= feat_idx_d;
      bus_q      <= bus_d;
    end
  end

endmodule

// File: rtl/mlp_inference_ctrl.sv
// MLP inference sequencer: collects a serial feature stream into the flat
// input bus of the combinational classifier, holds it for SETTLE_CYCLES,
// captures the class and returns it over a valid/ready result port.
// Optional build macro MLP_FAULT_INJ_EN adds fault_arm/fault_mask/res_faulty
// for XOR fault injection on the assembled input vector.
module mlp_inference_ctrl
  import mlp_ctrl_pkg::*;
#(
  parameter int unsigned NUM_A         = NUM_A_DEF,
  parameter int unsigned WIDTH_A       = WIDTH_A_DEF,
  parameter int unsigned OUTWIDTH      = OUTWIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
`ifdef MLP_FAULT_INJ_EN
  input  logic                       fault_arm,
  input  logic [NUM_A*WIDTH_A-1:0]   fault_mask,
  output logic                       res_faulty,
`endif
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_data,
  output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
  input  logic [OUTWIDTH-1:0]        mlp_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUTWIDTH-1:0]        res_class,
  output logic                       busy,
  output logic [CNT_W-1:0]           sample_cnt
);

  localparam int unsigned BUS_W = NUM_A * WIDTH_A;
  localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic [7:0]          settle_cnt_q, settle_cnt_d;
  logic [OUTWIDTH-1:0] res_class_q, res_class_d;
  logic                res_valid_q, res_valid_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic                fault_pend_q, fault_pend_d;
  logic                res_faulty_q, res_faulty_d;
  logic                fault_arm_s;

  logic                load_en_s;
  logic                asm_wr_s;
  logic                asm_last_s;
  logic [BUS_W-1:0]    inj_mask_s;

`ifdef MLP_FAULT_INJ_EN
  assign fault_arm_s = fault_arm;
  assign inj_mask_s  = fault_arm ? fault_mask : {BUS_W{1'b0}};
  assign res_faulty  = res_faulty_q;
`else
  assign fault_arm_s = 1'b0;
  assign inj_mask_s  = {BUS_W{1'b0}};
`endif

  assign load_en_s  = (state_q == LOAD);
  assign s_ready    = (state_q == LOAD);
  assign busy       = (state_q == SETTLE) || (state_q == HOLD);
  assign res_valid  = res_valid_q;
  assign res_class  = res_class_q;
  assign sample_cnt = sample_cnt_q;

  mlp_feat_assembler #(
    .NUM_A   (NUM_A),
    .WIDTH_A (WIDTH_A)
  ) u_feat_asm (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .load_en_i  (load_en_s),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .inj_mask_i (inj_mask_s),
    .wr_en_o    (asm_wr_s),
    .last_o     (asm_last_s),
    .bus_o      (mlp_inp)
  );

  // Sequencer next-state: load -> settle countdown -> hold result; clear overrides all
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    res_class_d  = res_class_q;
    res_valid_d  = res_valid_q;
    sample_cnt_d = sample_cnt_q;
    fault_pend_d = fault_pend_q;
    res_faulty_d = res_faulty_q;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
      end
      LOAD: begin
        if (asm_wr_s && asm_last_s) begin
          state_d      = SETTLE;
          settle_cnt_d = SETTLE_INIT;
          fault_pend_d = fault_arm_s;
        end else begin
          state_d = LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == 8'd0) begin
          res_class_d  = mlp_out;
          res_valid_d  = 1'b1;
          res_faulty_d = fault_pend_q;
          state_d      = HOLD;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d  = 1'b0;
          res_faulty_d = 1'b0;
          sample_cnt_d = sample_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d      = LOAD;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins over any transition or handshake decided above
    if (clear) begin
      state_d      = IDLE;
      settle_cnt_d = settle_cnt_q;
      res_class_d  = res_class_q;
      res_valid_d  = 1'b0;
      sample_cnt_d = sample_cnt_q;
      fault_pend_d = 1'b0;
      res_faulty_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Sequencer state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= 8'd0;
      res_class_q  <= '0;
      res_valid_q  <= 1'b0;
      sample_cnt_q <= '0;
      fault_pend_q <= 1'b0;
      res_faulty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      res_class_q  <= res_class_d;
      res_valid_q  <= res_valid_d;
      sample_cnt_q <= sample_cnt_d;
      fault_pend_q <= fault_pend_d;
      res_faulty_q <= res_faulty_d;
    end
  end

endmodule

// File: tb/tb_mlp_inference_ctrl.sv
// Self-checking bench for mlp_inference_ctrl: vector table of full samples
// with latency/hold checks, clear abort, random-gap scoreboard run, reset
// during SETTLE, and (with MLP_FAULT_INJ_EN) fault-injection checks.
module tb_mlp_inference_ctrl;

  localparam int NA  = 21;
  localparam int WA  = 4;
  localparam int OW  = 2;
  localparam int BUS = NA * WA;
  localparam int SC  = 4;
  localparam int CW  = 16;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             s_valid;
  logic             s_ready;
  logic [WA-1:0]    s_data;
  logic [BUS-1:0]   mlp_inp;
  logic [OW-1:0]    mlp_out;
  logic             res_valid;
  logic             res_ready;
  logic [OW-1:0]    res_class;
  logic             busy;
  logic [CW-1:0]    sample_cnt;
`ifdef MLP_FAULT_INJ_EN
  logic             fault_arm;
  logic [BUS-1:0]   fault_mask;
  logic             res_faulty;
`endif

  bit model_const;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [OW-1:0] cls;
    logic          flt;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0]     base;
    logic [3:0]     step;
    bit             const3;
    int             hold;
    logic [BUS-1:0] exp_vec;
    logic [OW-1:0]  exp_class;
    logic [3:0]     exp_s0;
    logic [3:0]     exp_s20;
  } vec_t;
  vec_t tbl[4];

  // Golden classifier stand-in: weighted feature sum folded to two bits
  function automatic logic [OW-1:0] mlp_model(input logic [BUS-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < NA; i++) s += int'(v[i*WA +: WA]) * (i + 1);
    return s[1:0] ^ s[3:2] ^ s[6:5];
  endfunction

  function automatic logic [BUS-1:0] build_vec(input logic [3:0] base, input logic [3:0] step);
    logic [BUS-1:0] v;
    logic [3:0]     t;
    v = '0;
    t = base;
    for (int i = 0; i < NA; i++) begin
      v[i*WA +: WA] = t;
      t = t + step;
    end
    return v;
  endfunction

  function automatic logic [BUS-1:0] rand_vec();
    logic [BUS-1:0] v;
    v = '0;
    for (int i = 0; i < NA; i++) v[i*WA +: WA] = 4'($urandom_range(15, 0));
    return v;
  endfunction

  assign mlp_out = model_const ? 2'd3 : mlp_model(mlp_inp);

  mlp_inference_ctrl #(
    .NUM_A         (NA),
    .WIDTH_A       (WA),
    .OUTWIDTH      (OW),
    .SETTLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
`ifdef MLP_FAULT_INJ_EN
    .fault_arm  (fault_arm),
    .fault_mask (fault_mask),
    .res_faulty (res_faulty),
`endif
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mlp_inp    (mlp_inp),
    .mlp_out    (mlp_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_class  (res_class),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each consumed result against the queue head
  always begin
    @(negedge clk);
    #2;
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_class", res_class, mon_e.cls);
`ifdef MLP_FAULT_INJ_EN
        chk("sb_faulty", res_faulty, mon_e.flt);
`endif
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the handshake
  task automatic send_feat(input logic [3:0] d, input bit gaps);
    int t;
    while (gaps && ($urandom_range(1, 0) == 1)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [BUS-1:0] v, input bit gaps);
    for (int i = 0; i < NA; i++) send_feat(v[i*WA +: WA], gaps);
  endtask

  task automatic wait_q_empty(input int budget);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("result_timeout", 128'(sb_q.size()), 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_first_cycle", s_ready, 0);
    @(negedge clk);
    chk("s_ready_second_cycle", s_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CW-1:0]  cnt_exp;
    logic [BUS-1:0] v;
    logic [BUS-1:0] prev;
    bit             done;

    rst_n = 1'b1; clear = 1'b0; s_valid = 1'b0; s_data = '0;
    res_ready = 1'b0; model_const = 1'b0; done = 1'b0;
`ifdef MLP_FAULT_INJ_EN
    fault_arm = 1'b0; fault_mask = '0;
`endif
    cnt_exp = '0;

    tbl[0] = '{base: 4'd1,  step: 4'd1, const3: 1'b1, hold: 10, exp_vec: '0, exp_class: '0, exp_s0: '0, exp_s20: '0};
    tbl[1] = '{base: 4'd0,  step: 4'd3, const3: 1'b0, hold: 0,  exp_vec: '0, exp_class: '0, exp_s0: '0, exp_s20: '0};
    tbl[2] = '{base: 4'hF,  step: 4'd7, const3: 1'b0, hold: 3,  exp_vec: '0, exp_class: '0, exp_s0: '0, exp_s20: '0};
    tbl[3] = '{base: 4'd5,  step: 4'd0, const3: 1'b1, hold: 1,  exp_vec: '0, exp_class: '0, exp_s0: '0, exp_s20: '0};
    for (int k = 0; k < 4; k++) begin
      tbl[k].exp_vec   = build_vec(tbl[k].base, tbl[k].step);
      tbl[k].exp_class = tbl[k].const3 ? 2'd3 : mlp_model(tbl[k].exp_vec);
      tbl[k].exp_s0    = tbl[k].base;
      tbl[k].exp_s20   = tbl[k].base + 4'(20 * int'(tbl[k].step));
    end

    // Reset values
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_class", res_class, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_mlp_inp", mlp_inp, 0);
    release_reset();

    // Table of full samples with settle latency and result-hold checks
    for (int k = 0; k < 4; k++) begin
      model_const = tbl[k].const3;
      res_ready   = 1'b0;
      sb_q.push_back('{cls: tbl[k].exp_class, flt: 1'b0});
      send_vec(tbl[k].exp_vec, 1'b0);
      chk("tbl_slice0", mlp_inp[3:0], tbl[k].exp_s0);
      chk("tbl_slice20", mlp_inp[BUS-1 -: 4], tbl[k].exp_s20);
      chk("tbl_bus", mlp_inp, tbl[k].exp_vec);
      chk("tbl_busy", busy, 1);
      for (int c = 1; c <= SC + 1; c++) begin
        chk("tbl_latency", res_valid, (c == SC + 1) ? 1 : 0);
        if (c <= SC) @(negedge clk);
      end
      chk("tbl_class", res_class, tbl[k].exp_class);
      s_valid = 1'b1;
      s_data  = 4'hA;
      for (int h = 0; h < tbl[k].hold; h++) begin
        @(negedge clk);
        chk("hold_s_ready", s_ready, 0);
        chk("hold_res_valid", res_valid, 1);
        chk("hold_class", res_class, tbl[k].exp_class);
        chk("hold_bus", mlp_inp, tbl[k].exp_vec);
      end
      s_valid   = 1'b0;
      res_ready = 1'b1;
      cnt_exp   = cnt_exp + 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("tbl_sample_cnt", sample_cnt, cnt_exp);
      chk("tbl_res_valid_low", res_valid, 0);
      chk("tbl_s_ready_back", s_ready, 1);
      chk("tbl_bus_after", mlp_inp, tbl[k].exp_vec);
    end

    // Clear after ten features, coinciding with an eleventh handshake
    model_const = 1'b0;
    prev = tbl[3].exp_vec;
    for (int i = 0; i < 10; i++) begin
      send_feat(4'h9, 1'b0);
      prev[i*WA +: WA] = 4'h9;
    end
    s_valid = 1'b1;
    s_data  = 4'hE;
    clear   = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    s_valid = 1'b0;
    chk("clr_s_ready", s_ready, 0);
    chk("clr_busy", busy, 0);
    chk("clr_bus_discard", mlp_inp, prev);
    chk("clr_sample_cnt", sample_cnt, cnt_exp);
    @(negedge clk);
    chk("clr_s_ready_back", s_ready, 1);
    v = rand_vec();
    sb_q.push_back('{cls: mlp_model(v), flt: 1'b0});
    res_ready = 1'b1;
    send_vec(v, 1'b0);
    wait_q_empty(100);
    res_ready = 1'b0;
    cnt_exp = cnt_exp + 1'b1;
    chk("clr_fresh_bus", mlp_inp, v);
    chk("clr_fresh_cnt", sample_cnt, cnt_exp);

    // Random valid gaps and random result back-pressure
    fork
      begin
        for (int s = 0; s < 100; s++) begin
          logic [BUS-1:0] rv;
          rv = rand_vec();
          sb_q.push_back('{cls: mlp_model(rv), flt: 1'b0});
          send_vec(rv, 1'b1);
        end
        wait_q_empty(2000);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          res_ready = ($urandom_range(1, 0) == 1);
        end
      end
    join
    res_ready = 1'b0;
    cnt_exp = cnt_exp + 16'd100;
    @(negedge clk);
    chk("rand_sample_cnt", sample_cnt, cnt_exp);

    // Reset asserted during SETTLE
    v = rand_vec();
    send_vec(v, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sample_cnt", sample_cnt, 0);
    chk("midrst_bus", mlp_inp, 0);
    cnt_exp = '0;
    release_reset();

`ifdef MLP_FAULT_INJ_EN
    // Armed injection flips bit 0 of the assembled vector
    fault_arm  = 1'b1;
    fault_mask = {{(BUS-1){1'b0}}, 1'b1};
    v = rand_vec();
    send_vec(v, 1'b0);
    chk("fi_bus_flipped", mlp_inp, v ^ fault_mask);
    sb_q.push_back('{cls: mlp_model(v ^ fault_mask), flt: 1'b1});
    res_ready = 1'b1;
    wait_q_empty(50);
    res_ready = 1'b0;
    fault_arm = 1'b0;
    v = rand_vec();
    send_vec(v, 1'b0);
    chk("fi_bus_exact", mlp_inp, v);
    sb_q.push_back('{cls: mlp_model(v), flt: 1'b0});
    res_ready = 1'b1;
    wait_q_empty(50);
    res_ready = 1'b0;
    cnt_exp = cnt_exp + 16'd2;
    chk("fi_sample_cnt", sample_cnt, cnt_exp);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mlp_inference_ctrl.md
Name: mlp_inference_ctrl

Overview:
Sequencer that feeds the combinational bespoke MLP classifier (`top`: `inp`/`out`) from a serial feature stream.
- Accepts NUM_A features of WIDTH_A bits, one per handshake, and assembles them into the flat input bus.
- Holds the bus stable for a programmable settle time (slow printed logic), then captures the class.
- Returns the class over a valid/ready result port.
- Sits between the sample source / test harness and the MLP core.

Parameters:
NUM_A, 21, number of input features per sample
WIDTH_A, 4, bits per feature
OUTWIDTH, 2, class index width
SETTLE_CYCLES, 4, clock cycles the MLP input is held before output capture (legal range 1..255)
CNT_W, 16, width of completed-sample counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort of current sample
s_valid  in  1  feature valid
s_ready  out  1  feature accepted when s_valid & s_ready
s_data  in  WIDTH_A  feature value
mlp_inp  out  NUM_A*WIDTH_A  registered bus to MLP `inp`
mlp_out  in  OUTWIDTH  MLP `out`
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid & res_ready
res_class  out  OUTWIDTH  captured class
busy  out  1  high in SETTLE or HOLD
sample_cnt  out  CNT_W  completed (consumed) samples, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: state=IDLE, mlp_inp=0, res_class=0, res_valid=0, feat_idx=0, settle_cnt=0, sample_cnt=0.
- Derived outputs: s_ready=(state==LOAD); busy=(state==SETTLE|HOLD). Both are 0 during reset.
- IDLE: always moves to LOAD on the next edge. It is a one-cycle guard after reset or clear.
- LOAD, per handshake:
  - s_data is written to mlp_inp[(feat_idx+1)*WIDTH_A-1 : feat_idx*WIDTH_A].
  - feat_idx increments. The first feature received is index 0.
  - Unwritten slices keep their previous value; every sample overwrites all NUM_A slices.
- LOAD to SETTLE: on the handshake with feat_idx==NUM_A-1 (edge E0), set feat_idx=0 and settle_cnt=SETTLE_CYCLES-1. mlp_inp is complete from E0.
- SETTLE:
  - settle_cnt decrements each cycle.
  - On the edge where settle_cnt==0: res_class<=mlp_out, res_valid<=1, state=HOLD.
  - res_valid therefore first reads high SETTLE_CYCLES cycles after E0.
- HOLD:
  - res_valid and res_class are held stable until res_ready.
  - On the result handshake: res_valid<=0, sample_cnt++, state=LOAD.
  - s_ready is 0 throughout SETTLE and HOLD, so mlp_inp never changes while a result is pending.
- Stall handling: s_valid low in LOAD stalls with no change. res_ready high outside HOLD is ignored.
- clear (synchronous, highest priority after reset), from any state:
  - state=IDLE, feat_idx=0, res_valid=0.
  - sample_cnt and mlp_inp are unchanged.
  - A clear coinciding with a handshake discards that handshake; sample_cnt does not increment.
- Counter wrap: sample_cnt wraps 2^CNT_W-1 to 0 silently.
- Reset mid-operation: immediate return to reset values; the partial sample is lost.

Optional Feature:
MLP_FAULT_INJ_EN — fault-injection hook for fault-analysis campaigns.
- When defined, adds ports fault_arm (in, 1), fault_mask (in, NUM_A*WIDTH_A) and res_faulty (out, 1).
- At the E0 edge, if fault_arm=1, mlp_inp is updated to assembled_vector XOR fault_mask. The final slice uses the incoming s_data.
- res_faulty is set alongside res_valid and cleared with it. It resets to 0.
- When undefined: these ports are absent and mlp_inp is exactly the received features.

Decomposition:
- Package mlp_ctrl_pkg holds:
  - state encoding constants IDLE=2'd0, LOAD=2'd1, SETTLE=2'd2, HOLD=2'd3;
  - default NUM_A, WIDTH_A and OUTWIDTH constants;
  - the helper giving feat_idx width, clog2(NUM_A).
- One sub-module, mlp_feat_assembler: feat_idx counter plus slice write into mlp_inp, with wr_en/last outputs.
- The FSM, settle counter, result register and sample counter stay in mlp_inference_ctrl.

Test Plan:
- Reset then stream 21 features 1..15,0..5 back-to-back with MLP model out=2'd3 and SETTLE_CYCLES=4 -> mlp_inp slice0=1, slice20=5; res_valid high exactly 4 cycles after the last handshake; res_class=3; sample_cnt=1 after res_ready.
- Hold res_ready low for 10 cycles in HOLD while s_valid=1 -> s_ready=0, res_class and mlp_inp stable, no feature consumed; the next sample starts after res_ready.
- Random s_valid gaps (50%) over 100 samples against a golden MLP model -> all classes match; sample_cnt=100.
- Assert clear after feature 10, then send a full fresh sample -> first result reflects only the fresh sample; sample_cnt unchanged by the abort.
- Drop rst_n during SETTLE -> res_valid=0, s_ready=0 immediately; s_ready=1 the second cycle after release.
- MLP_FAULT_INJ_EN with fault_arm=1 and fault_mask=bit0 set -> mlp_inp slice0 LSB flipped; res_faulty=1 with the result. With fault_arm=0 -> res_faulty=0 and the bus is exact.
